// File: rtl/uart_frame_rx.sv
// Frame deframer behind a FWFT UART receive FIFO: hunts SOF, buffers LEN payload bytes, checks
// length and checksum, and replays good payloads on a valid/ready byte stream.
module uart_frame_rx #(
  parameter logic [7:0]  SOF     = 8'h7E,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);

  localparam int unsigned IdxW  = $clog2(MAX_LEN + 1);
  localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmrW  = $clog2(TIMEOUT + 1);

  localparam logic [8:0]      MaxLen  = 9'(MAX_LEN);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StOut} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] len_q, len_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            frm_ok_d, frm_err_d;
  logic [1:0]      err_code_d;
  logic [7:0]      err_cnt_d;
  logic            mem_we;
  logic            err_set;
  logic [1:0]      err_val;
  logic [7:0]      mem_q [MAX_LEN];

  // No pops while draining a frame: the FIFO absorbs downstream backpressure.
  assign rd_uart = ~rx_empty & ~reset & (state_q != StOut);
  assign m_valid = (state_q == StOut);
  assign m_last  = m_valid & (rd_idx_q == len_q - IdxOne);
  assign m_data  = m_valid ? mem_q[rd_idx_q[AddrW-1:0]] : 8'h00;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    acc_d      = acc_q;
    timer_d    = timer_q;
    frm_ok_d   = 1'b0;
    frm_err_d  = 1'b0;
    err_code_d = err_code;
    err_cnt_d  = err_cnt;
    mem_we     = 1'b0;
    err_set    = 1'b0;
    err_val    = 2'b00;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (rd_uart && (r_data == SOF)) begin
          acc_d   = 8'h00;
          state_d = StLen;
        end
      end
      StLen, StPayload, StChk: begin
        if (rd_uart) begin
          timer_d = '0;
          if (state_q == StLen) begin
            if ((r_data == 8'h00) || ({1'b0, r_data} > MaxLen)) begin
              err_set = 1'b1;
              err_val = 2'b01;
            end else begin
              len_d    = IdxW'(r_data);
              acc_d    = r_data;
              wr_idx_d = '0;
              state_d  = StPayload;
            end
          end else if (state_q == StPayload) begin
            mem_we   = 1'b1;
            acc_d    = acc_q + r_data;
            wr_idx_d = wr_idx_q + IdxOne;
            if (wr_idx_q + IdxOne == len_q) state_d = StChk;
          end else begin
            if (acc_q + r_data == 8'h00) begin
              frm_ok_d = 1'b1;
              rd_idx_d = '0;
              state_d  = StOut;
            end else begin
              err_set = 1'b1;
              err_val = 2'b10;
            end
          end
        end else if (timer_q == TmrLast) begin
          err_set = 1'b1;
          err_val = 2'b11;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StOut: begin
        timer_d = '0;
        if (m_ready) begin
          if (rd_idx_q == len_q - IdxOne) state_d = StIdle;
          else rd_idx_d = rd_idx_q + IdxOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_set) begin
      frm_err_d  = 1'b1;
      err_code_d = err_val;
      if (err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'h01;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      acc_q    <= 8'h00;
      timer_q  <= '0;
      frm_ok   <= 1'b0;
      frm_err  <= 1'b0;
      err_code <= 2'b00;
      err_cnt  <= 8'h00;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      acc_q    <= acc_d;
      timer_q  <= timer_d;
      frm_ok   <= frm_ok_d;
      frm_err  <= frm_err_d;
      err_code <= err_code_d;
      err_cnt  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_idx_q[AddrW-1:0]] <= r_data;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Frame deframer directly downstream of the UART receive FIFO; consumes bytes through the FIFO's rd_uart/r_data/rx_empty read port.
- Each frame is SOF, LEN, payload, CHK. The block hunts for SOF, collects and buffers the payload, and checks length and checksum.
- Only frames that pass both checks are released on a valid/ready byte stream to the command layer.
- Bad frames are dropped and reported with an error code and a saturating error counter.

Parameters:
- SOF, 8'h7E, start-of-frame byte.
- MAX_LEN, 16, maximum payload bytes; sets internal buffer depth.
- TIMEOUT, 20000, idle clk cycles allowed mid-frame before abort; must be ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_empty  in  1  receive FIFO empty flag
- r_data  in  8  FIFO head byte, valid whenever rx_empty=0 (first-word-fall-through)
- rd_uart  out  1  FIFO pop strobe
- m_data  out  8  payload byte out
- m_valid  out  1  m_data valid
- m_last  out  1  final payload byte of the frame
- m_ready  in  1  downstream accepts byte
- frm_ok  out  1  one-cycle pulse: good frame accepted
- frm_err  out  1  one-cycle pulse: frame dropped
- err_code  out  2  01 bad LEN, 10 bad CHK, 11 timeout; held until the next frm_err
- err_cnt  out  8  saturating count of frm_err pulses

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high, named reset.
- Reset values:
  - State goes to IDLE.
  - rd_uart, m_valid, m_last, frm_ok, frm_err = 0.
  - err_code = 00, err_cnt = 0, m_data = 0.
  - Timer, indices and checksum cleared.
- Reset mid-frame discards the partial frame, with no error pulse.
- Byte accept: rd_uart = ~rx_empty & (state ∈ {IDLE, LEN, PAYLOAD, CHK}), combinational. A byte is consumed on any cycle with rd_uart=1, at most one byte per cycle.
- IDLE:
  - Consumed bytes ≠ SOF are discarded silently.
  - SOF → LEN; checksum accumulator cleared.
- LEN:
  - Byte L with L == 0 or L > MAX_LEN → frm_err, err_code=01, back to IDLE.
  - Otherwise latch len=L, acc=L, wr_idx=0, → PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[wr_idx]; acc += byte (mod 256); wr_idx++.
  - After byte number len → CHK.
- CHK:
  - acc + byte == 8'h00 (mod 256) → OUT, with frm_ok pulsed on the following cycle.
  - Otherwise frm_err, err_code=10, → IDLE.
- Timeout:
  - In LEN, PAYLOAD and CHK, a timer counts consecutive cycles with rx_empty=1.
  - The timer clears on every consumed byte.
  - Reaching TIMEOUT → frm_err, err_code=11, → IDLE.
  - The timer is inactive in IDLE and OUT.
- OUT:
  - rd_uart forced 0 (FIFO absorbs backpressure).
  - m_valid=1 from the cycle frm_ok is high; m_data = buf[rd_idx].
  - Transfer on m_valid & m_ready → rd_idx++.
  - m_last=1 when rd_idx == len-1. Transfer of the last byte → m_valid=0 next cycle, → IDLE.
  - m_data/m_last remain stable while m_valid=1 and m_ready=0.
- Latency:
  - CHK byte consumed on cycle N → frm_ok and m_valid on N+1.
  - With m_ready held high, one byte per cycle: frame of L bytes drains on cycles N+1..N+L.
- err_cnt increments on each frm_err and saturates at 255.
- Checksum arithmetic is 8-bit wrap-around. SOF is excluded from the checksum.
- A SOF value appearing inside LEN/PAYLOAD/CHK is treated as data; there is no resync.
- Buffer: MAX_LEN×8 registers or distributed RAM. wr_idx/rd_idx width = $clog2(MAX_LEN+1).

Test Plan:
- Good frame: 7E 03 AA AB AC FC, m_ready=1 → frm_ok once; m_data AA,AB,AC on 3 consecutive cycles; m_last only on AC; err_cnt=0.
- Bad checksum: 7E 03 AA AB AC 00 → frm_err, err_code=10, err_cnt=1, m_valid never asserted.
- Bad length: 7E 00 then 7E 11 (MAX_LEN=16) → two frm_err, err_code=01, err_cnt=2.
- Leading garbage: 55 12 7E 01 5A A5 → garbage consumed with no pulse; frm_ok; single byte 5A with m_last=1.
- Timeout (TIMEOUT=64): 7E 02 11, then FIFO empty 64 cycles → frm_err, err_code=11; a following good frame is still accepted.
- Backpressure: good 3-byte frame with m_ready toggled 0/1 → data held stable while stalled; rd_uart=0 throughout OUT. A second frame queued in the FIFO is consumed only after m_last transfers.
